// File: rtl/scpu_pkg.sv
// scpu_pkg: shared definitions for the scpu RV32I core.
//   - opcode, funct3 and funct7 field constants
//   - ALU operation enum used between decode and scpu_alu
//   - machine-mode CSR addresses and trap cause codes
package scpu_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // System funct3
    localparam logic [2:0] F3_PRIV  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_CSRRS = 3'b010;
    localparam logic [2:0] F3_CSRRC = 3'b011;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Full encodings of the two privileged instructions
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Trap causes
    localparam logic [31:0] CAUSE_MEXT  = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ECALL = 32'd11;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

endpackage

// File: rtl/data_memory_face.sv
// data_memory_face: data-memory bus between the core and a data memory
// with synchronous write and combinational read.
//   addr  : byte address (core -> mem)
//   wdata : lane-replicated store data (core -> mem)
//   be    : byte enables (core -> mem)
//   we    : write strobe (core -> mem)
//   rdata : aligned word at addr (mem -> core)
interface data_memory_face;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rdata;

    modport cpu (output addr, output wdata, output be, output we, input rdata);
    modport mem (input addr, input wdata, input be, input we, output rdata);
endinterface

// File: rtl/scpu_alu.sv
// scpu_alu: combinational 32-bit ALU.
//   a, b   : operands
//   op     : operation select (alu_op_e)
//   result : operation result
//   zero   : result == 0
module scpu_alu
    import scpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/scpu.sv
// scpu: single-cycle RV32I core with machine-mode external interrupt.
//   clk     : clock, all state updates on rising edge
//   rst     : asynchronous active-low reset
//   ext_int : level-sensitive external interrupt request
//   inst_in : instruction at PC_out (combinational ROM)
//   PC_out  : current program counter
//   mem_if  : data memory bus (cpu side)
module scpu
    import scpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_int,
    input  logic [31:0]       inst_in,
    output logic [31:0]       PC_out,
    data_memory_face.cpu      mem_if
);

    logic [31:0] pc;
    logic [31:0] rf [0:31];
    logic        mie, mpie;
    logic [31:0] mtvec, mepc, mcause;

    // Instruction fields
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] csr_addr;
    assign opcode   = inst_in[6:0];
    assign rd       = inst_in[11:7];
    assign f3       = inst_in[14:12];
    assign rs1      = inst_in[19:15];
    assign rs2      = inst_in[24:20];
    assign f7       = inst_in[31:25];
    assign csr_addr = inst_in[31:20];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
    assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
    assign imm_b = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
    assign imm_u = {inst_in[31:12], 12'b0};
    assign imm_j = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};

    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

    logic [31:0] pc_plus4, trap_vec, eff_addr;
    assign pc_plus4 = pc + 32'd4;
    assign trap_vec = {mtvec[31:2], 2'b00};
    assign eff_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    logic irq_take;
    assign irq_take = ext_int & mie;

    // ALU operand and operation selection
    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_e     alu_op;
    logic        alu_legal, alu_zero;

    always_comb begin
        alu_a     = rs1_val;
        alu_b     = ((opcode == OP_REG) || (opcode == OP_BRANCH)) ? rs2_val : imm_i;
        alu_op    = ALU_ADD;
        alu_legal = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (f3)
                F3_BEQ, F3_BNE:   alu_op = ALU_SUB;
                F3_BLT, F3_BGE:   alu_op = ALU_SLT;
                F3_BLTU, F3_BGEU: alu_op = ALU_SLTU;
                default:          alu_op = ALU_ADD;
            endcase
        end else if ((opcode == OP_IMM) || (opcode == OP_REG)) begin
            case (f3)
                F3_ADD:  alu_op = ((opcode == OP_REG) && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
                F3_SLL:  alu_op = ALU_SLL;
                F3_SLT:  alu_op = ALU_SLT;
                F3_SLTU: alu_op = ALU_SLTU;
                F3_XOR:  alu_op = ALU_XOR;
                F3_SR:   alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                F3_OR:   alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
            // funct7 only qualifies shift immediates and register ops
            if (opcode == OP_REG)
                alu_legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            else if (f3 == F3_SLL)
                alu_legal = (f7 == F7_BASE);
            else if (f3 == F3_SR)
                alu_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            else
                alu_legal = 1'b1;
        end
    end

    scpu_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Load lane extraction
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic        load_legal;

    always_comb begin
        case (eff_addr[1:0])
            2'd0:    ld_byte = mem_if.rdata[7:0];
            2'd1:    ld_byte = mem_if.rdata[15:8];
            2'd2:    ld_byte = mem_if.rdata[23:16];
            default: ld_byte = mem_if.rdata[31:24];
        endcase
        ld_half    = eff_addr[1] ? mem_if.rdata[31:16] : mem_if.rdata[15:0];
        load_legal = 1'b1;
        case (f3)
            F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
            F3_W:    load_val = mem_if.rdata;
            F3_BU:   load_val = {24'b0, ld_byte};
            F3_HU:   load_val = {16'b0, ld_half};
            default: begin
                load_val   = '0;
                load_legal = 1'b0;
            end
        endcase
    end

    // Store lane placement
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        st_be    = '0;
        st_wdata = rs2_val;
        case (f3)
            F3_B: begin
                st_be    = 4'b0001 << eff_addr[1:0];
                st_wdata = {4{rs2_val[7:0]}};
            end
            F3_H: begin
                st_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_val[15:0]}};
            end
            F3_W:    st_be = 4'b1111;
            default: st_be = '0;
        endcase
    end

    // CSR read and write value
    logic [31:0] csr_rdata, csr_wval;

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = {24'b0, mpie, 3'b0, mie, 3'b0};
            CSR_MTVEC:   csr_rdata = mtvec;
            CSR_MEPC:    csr_rdata = mepc;
            CSR_MCAUSE:  csr_rdata = mcause;
            default:     csr_rdata = '0;
        endcase
        case (f3)
            F3_CSRRS: csr_wval = csr_rdata | rs1_val;
            F3_CSRRC: csr_wval = csr_rdata & ~rs1_val;
            default:  csr_wval = rs1_val;
        endcase
    end

    // Control and write-back selection
    logic        rd_we, is_store, csr_we, is_ecall, is_mret, take;
    logic [31:0] rd_wdata, pc_next;

    always_comb begin
        rd_we    = 1'b0;
        rd_wdata = alu_res;
        pc_next  = pc_plus4;
        is_store = 1'b0;
        csr_we   = 1'b0;
        is_ecall = 1'b0;
        is_mret  = 1'b0;
        take     = 1'b0;
        case (opcode)
            OP_LUI: begin
                rd_we    = 1'b1;
                rd_wdata = imm_u;
            end
            OP_AUIPC: begin
                rd_we    = 1'b1;
                rd_wdata = pc + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_wdata = pc_plus4;
                pc_next  = pc + imm_j;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    rd_we    = 1'b1;
                    rd_wdata = pc_plus4;
                    pc_next  = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (f3)
                    F3_BEQ:           take = alu_zero;
                    F3_BNE:           take = ~alu_zero;
                    F3_BLT, F3_BLTU:  take = alu_res[0];
                    F3_BGE, F3_BGEU:  take = ~alu_res[0];
                    default:          take = 1'b0;
                endcase
                if (take)
                    pc_next = pc + imm_b;
            end
            OP_LOAD: begin
                rd_we    = load_legal;
                rd_wdata = load_val;
            end
            OP_STORE: is_store = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
            OP_IMM, OP_REG: rd_we = alu_legal;
            OP_SYSTEM: begin
                if ((f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC)) begin
                    rd_we    = 1'b1;
                    rd_wdata = csr_rdata;
                    csr_we   = (f3 == F3_CSRRW) || (rs1 != 5'd0);
                end else if (inst_in == INST_ECALL) begin
                    is_ecall = 1'b1;
                    pc_next  = trap_vec;
                end else if (inst_in == INST_MRET) begin
                    is_mret  = 1'b1;
                    pc_next  = mepc;
                end
            end
            default: ;
        endcase
    end

    // Reset gates the strobe combinationally so nothing writes on an aborting edge
    logic store_en;
    assign store_en     = is_store & ~irq_take & rst;
    assign mem_if.we    = store_en;
    assign mem_if.be    = store_en ? st_be : '0;
    assign mem_if.addr  = eff_addr;
    assign mem_if.wdata = st_wdata;
    assign PC_out       = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= '0;
            mepc   <= '0;
            mcause <= '0;
            for (int unsigned i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (irq_take) begin
            // Interrupt squashes the whole instruction, including ECALL/MRET
            mepc   <= {pc[31:2], 2'b00};
            mcause <= CAUSE_MEXT;
            mpie   <= mie;
            mie    <= 1'b0;
            pc     <= trap_vec;
        end else begin
            pc <= pc_next;
            if (rd_we && (rd != 5'd0))
                rf[rd] <= rd_wdata;
            if (is_ecall) begin
                mepc   <= {pc[31:2], 2'b00};
                mcause <= CAUSE_ECALL;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (is_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie  <= csr_wval[3];
                        mpie <= csr_wval[7];
                    end
                    CSR_MTVEC:  mtvec  <= csr_wval;
                    CSR_MEPC:   mepc   <= {csr_wval[31:2], 2'b00};
                    CSR_MCAUSE: mcause <= csr_wval;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scpu.sv
module tb_scpu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_int;
    logic [31:0] inst_in;
    logic [31:0] PC_out;

    data_memory_face mif ();

    scpu dut (
        .clk     (clk),
        .rst     (rst),
        .ext_int (ext_int),
        .inst_in (inst_in),
        .PC_out  (PC_out),
        .mem_if  (mif)
    );

    always #5 clk = ~clk;

    logic [31:0] rom  [0:1023];
    logic [31:0] dmem [0:255];

    always_comb inst_in = rom[PC_out[11:2]];
    assign mif.rdata = dmem[mif.addr[9:2]];

    always @(posedge clk) begin
        if (mif.we) begin
            for (int b = 0; b < 4; b++)
                if (mif.be[b]) dmem[mif.addr[9:2]][8*b +: 8] <= mif.wdata[8*b +: 8];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Encoders
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] SYS = 7'b1110011;

    typedef struct {
        string       name;
        logic        ext;
        logic [31:0] pc;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [4:0]  rd;
        logic [31:0] rd_val;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic ext, input logic [31:0] pc,
                                input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic chk_rd, input logic [4:0] rd,
                                input logic [31:0] rd_val);
        vec_t v;
        v.name = name; v.ext = ext; v.pc = pc; v.we = we; v.be = be; v.addr = addr;
        v.wdata = wdata; v.chk_rd = chk_rd; v.rd = rd; v.rd_val = rd_val;
        return v;
    endfunction

    // Entered just after a falling edge; leaves just after the next one.
    task automatic run_row(input vec_t v);
        ext_int = v.ext;
        #1;
        chk({v.name, ".pc"}, PC_out, v.pc);
        chk({v.name, ".we"}, {31'b0, mif.we}, {31'b0, v.we});
        chk({v.name, ".be"}, {28'b0, mif.be}, {28'b0, v.be});
        if (v.we) begin
            chk({v.name, ".addr"}, mif.addr, v.addr);
            chk({v.name, ".wdata"}, mif.wdata, v.wdata);
        end
        @(posedge clk);
        @(negedge clk);
        if (v.chk_rd) chk({v.name, ".rd"}, dut.rf[v.rd], v.rd_val);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) run_row(tbl[i]);
        tbl.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0000_0013;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        ext_int = 1'b0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        clear_rom();

        // Program A: ALU, memory, control flow, illegal encoding
        rom[0]  = enc_i(12'd5,   5'd0, 3'd0, 5'd1, IMM);           // addi x1,x0,5
        rom[1]  = enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, IMM);           // addi x2,x0,-3
        rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);            // add x3,x1,x2
        rom[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4);            // sltu x4,x1,x2
        rom[4]  = {20'hA1B2C, 5'd5, 7'b0110111};                   // lui x5,0xA1B2C
        rom[5]  = enc_i(12'h3D4, 5'd5, 3'd0, 5'd5, IMM);           // addi x5,x5,0x3D4
        rom[6]  = enc_s(12'd16, 5'd5, 5'd0, 3'd2);                 // sw x5,16(x0)
        rom[7]  = enc_i(12'd19, 5'd0, 3'd0, 5'd6, LD);             // lb x6,19(x0)
        rom[8]  = enc_i(12'd19, 5'd0, 3'd4, 5'd7, LD);             // lbu x7,19(x0)
        rom[9]  = enc_i(12'd18, 5'd0, 3'd1, 5'd8, LD);             // lh x8,18(x0)
        rom[10] = enc_i(12'h077, 5'd0, 3'd0, 5'd9, IMM);           // addi x9,x0,0x77
        rom[11] = enc_s(12'd17, 5'd9, 5'd0, 3'd0);                 // sb x9,17(x0)
        rom[12] = enc_i(12'd16, 5'd0, 3'd2, 5'd10, LD);            // lw x10,16(x0)
        rom[13] = enc_b(13'd8, 5'd1, 5'd1, 3'd0);                  // beq x1,x1,+8
        rom[14] = enc_i(12'd1, 5'd0, 3'd0, 5'd11, IMM);            // addi x11,x0,1 (skipped)
        rom[15] = enc_b(13'd8, 5'd2, 5'd1, 3'd0);                  // beq x1,x2,+8
        rom[16] = enc_j(21'd8, 5'd1);                              // jal x1,+8
        rom[17] = enc_j(21'd12, 5'd0);                             // jal x0,+12
        rom[18] = enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'b1100111);      // jalr x0,0(x1)
        rom[20] = enc_i(12'd7, 5'd0, 3'd0, 5'd0, IMM);             // addi x0,x0,7
        rom[21] = 32'hFFFF_FFFF;                                   // illegal
        rom[22] = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd12);           // slt x12,x2,x1
        rom[23] = enc_i(12'h401, 5'd2, 3'd5, 5'd13, IMM);          // srai x13,x2,1
        rom[24] = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd14);           // sub x14,x1,x2

        repeat (2) @(negedge clk);
        #1;
        chk("reset.pc", PC_out, 32'h0);
        chk("reset.we", {31'b0, mif.we}, 32'h0);
        chk("reset.be", {28'b0, mif.be}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        tbl.push_back(mk("addi1",  0, 32'h00, 0, 4'h0, 0, 0,             1, 5'd1,  32'd5));
        tbl.push_back(mk("addi2",  0, 32'h04, 0, 4'h0, 0, 0,             1, 5'd2,  32'hFFFF_FFFD));
        tbl.push_back(mk("add",    0, 32'h08, 0, 4'h0, 0, 0,             1, 5'd3,  32'd2));
        tbl.push_back(mk("sltu",   0, 32'h0C, 0, 4'h0, 0, 0,             1, 5'd4,  32'd1));
        tbl.push_back(mk("lui",    0, 32'h10, 0, 4'h0, 0, 0,             1, 5'd5,  32'hA1B2_C000));
        tbl.push_back(mk("addi5",  0, 32'h14, 0, 4'h0, 0, 0,             1, 5'd5,  32'hA1B2_C3D4));
        tbl.push_back(mk("sw",     0, 32'h18, 1, 4'hF, 32'h10, 32'hA1B2_C3D4, 0, 5'd0, 0));
        tbl.push_back(mk("lb",     0, 32'h1C, 0, 4'h0, 0, 0,             1, 5'd6,  32'hFFFF_FFA1));
        tbl.push_back(mk("lbu",    0, 32'h20, 0, 4'h0, 0, 0,             1, 5'd7,  32'h0000_00A1));
        tbl.push_back(mk("lh",     0, 32'h24, 0, 4'h0, 0, 0,             1, 5'd8,  32'hFFFF_A1B2));
        tbl.push_back(mk("addi9",  0, 32'h28, 0, 4'h0, 0, 0,             1, 5'd9,  32'h77));
        tbl.push_back(mk("sb",     0, 32'h2C, 1, 4'h2, 32'h11, 32'h7777_7777, 0, 5'd0, 0));
        tbl.push_back(mk("lw",     0, 32'h30, 0, 4'h0, 0, 0,             1, 5'd10, 32'hA1B2_77D4));
        tbl.push_back(mk("beq_t",  0, 32'h34, 0, 4'h0, 0, 0,             0, 5'd0,  0));
        tbl.push_back(mk("beq_nt", 0, 32'h3C, 0, 4'h0, 0, 0,             1, 5'd11, 32'd0));
        tbl.push_back(mk("jal",    0, 32'h40, 0, 4'h0, 0, 0,             1, 5'd1,  32'h44));
        tbl.push_back(mk("jalr",   0, 32'h48, 0, 4'h0, 0, 0,             0, 5'd0,  0));
        tbl.push_back(mk("jal_x0", 0, 32'h44, 0, 4'h0, 0, 0,             0, 5'd0,  0));
        tbl.push_back(mk("wr_x0",  0, 32'h50, 0, 4'h0, 0, 0,             1, 5'd0,  32'd0));
        tbl.push_back(mk("illeg",  0, 32'h54, 0, 4'h0, 0, 0,             0, 5'd0,  0));
        tbl.push_back(mk("slt",    0, 32'h58, 0, 4'h0, 0, 0,             1, 5'd12, 32'd1));
        tbl.push_back(mk("srai",   0, 32'h5C, 0, 4'h0, 0, 0,             1, 5'd13, 32'hFFFF_FFFE));
        tbl.push_back(mk("sub",    0, 32'h60, 0, 4'h0, 0, 0,             1, 5'd14, 32'd71));
        tbl.push_back(mk("nop",    0, 32'h64, 0, 4'h0, 0, 0,             1, 5'd3,  32'd2));
        run_tbl();
        chk("dmem.word4", dmem[4], 32'hA1B2_77D4);

        // Mid-run asynchronous reset
        #2;
        rst = 1'b0;
        #1;
        chk("midrst.pc", PC_out, 32'h0);
        chk("midrst.x3", dut.rf[3], 32'h0);
        @(negedge clk);

        // Program B: CSRs, interrupt entry/return, masked interrupt, ECALL
        clear_rom();
        rom[0]  = enc_i(12'h100, 5'd0, 3'd0, 5'd1, IMM);           // addi x1,x0,0x100
        rom[1]  = enc_i(12'h305, 5'd1, 3'd1, 5'd0, SYS);           // csrrw x0,mtvec,x1
        rom[2]  = enc_i(12'd8, 5'd0, 3'd0, 5'd2, IMM);             // addi x2,x0,8
        rom[3]  = enc_i(12'h300, 5'd2, 3'd2, 5'd0, SYS);           // csrrs x0,mstatus,x2
        rom[4]  = enc_i(12'h055, 5'd0, 3'd0, 5'd5, IMM);           // addi x5,x0,0x55
        rom[5]  = enc_s(12'h040, 5'd5, 5'd0, 3'd2);                // sw x5,0x40(x0)
        rom[6]  = enc_i(12'd1, 5'd0, 3'd0, 5'd8, IMM);             // addi x8,x0,1
        rom[7]  = enc_i(12'h300, 5'd2, 3'd3, 5'd0, SYS);           // csrrc x0,mstatus,x2
        rom[8]  = 32'h0000_0073;                                   // ecall
        rom[64] = enc_i(12'h342, 5'd0, 3'd2, 5'd6, SYS);           // csrrs x6,mcause,x0
        rom[65] = enc_i(12'h341, 5'd0, 3'd2, 5'd7, SYS);           // csrrs x7,mepc,x0
        rom[66] = 32'h3020_0073;                                   // mret
        rst = 1'b1;

        tbl.push_back(mk("b_addi1", 0, 32'h00, 0, 4'h0, 0, 0, 1, 5'd1, 32'h100));
        tbl.push_back(mk("b_mtvec", 0, 32'h04, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        tbl.push_back(mk("b_addi2", 0, 32'h08, 0, 4'h0, 0, 0, 1, 5'd2, 32'd8));
        tbl.push_back(mk("b_setmie",0, 32'h0C, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        tbl.push_back(mk("b_addi5", 0, 32'h10, 0, 4'h0, 0, 0, 1, 5'd5, 32'h55));
        tbl.push_back(mk("b_irqsw", 1, 32'h14, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        run_tbl();
        chk("irq.dmem_untouched", dmem[16], 32'h0);
        chk("irq.mepc", dut.mepc, 32'h14);

        tbl.push_back(mk("b_mcause",1, 32'h100, 0, 4'h0, 0, 0, 1, 5'd6, 32'h8000_000B));
        tbl.push_back(mk("b_mepc",  0, 32'h104, 0, 4'h0, 0, 0, 1, 5'd7, 32'h14));
        tbl.push_back(mk("b_mret",  0, 32'h108, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        run_tbl();
        chk("mret.mie", {31'b0, dut.mie}, 32'd1);

        tbl.push_back(mk("b_sw",    0, 32'h14, 1, 4'hF, 32'h40, 32'h55, 0, 5'd0, 0));
        tbl.push_back(mk("b_addi8", 0, 32'h18, 0, 4'h0, 0, 0, 1, 5'd8, 32'd1));
        tbl.push_back(mk("b_clrmie",0, 32'h1C, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        tbl.push_back(mk("b_ecall", 1, 32'h20, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        tbl.push_back(mk("b_cause2",0, 32'h100, 0, 4'h0, 0, 0, 1, 5'd6, 32'd11));
        tbl.push_back(mk("b_mepc2", 0, 32'h104, 0, 4'h0, 0, 0, 1, 5'd7, 32'h20));
        tbl.push_back(mk("b_end",   0, 32'h108, 0, 4'h0, 0, 0, 0, 5'd0, 0));
        run_tbl();
        chk("store.dmem", dmem[16], 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scpu.md
# scpu

Single-cycle RV32I processor core with machine-mode external-interrupt support. Each rising clock edge retires one instruction fetched from a combinational instruction ROM. Data accesses use the `data_memory_face` interface (`cpu` modport). The core sits in the SoC between `instruction_memory`, which is 1024×32, combinational and indexed by `PC_out[11:2]`, and a data memory with synchronous write and combinational read.

## Interface
- No parameters. Reset PC is fixed at 32'h0000_0000.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `ext_int` in 1: external interrupt request; level-sensitive, no synchronizer.
- `inst_in` in 32: instruction at `PC_out`; valid combinationally in the same cycle.
- `PC_out` out 32: current program counter.
- `mem_if` interface `data_memory_face.cpu`, with these signals:
  - `addr` out 32: byte address.
  - `wdata` out 32: lane-replicated store data.
  - `be` out 4: byte enables.
  - `we` out 1: write strobe.
  - `rdata` in 32: combinational read data for the aligned word at `addr`.

## Operation
- Supported instructions: LUI, AUIPC, JAL, JALR, the six branches, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops, CSRRW/CSRRS/CSRRC (register forms), ECALL and MRET.
- Any other encoding, including FENCE, executes as a NOP: PC+4 and no writes.
- Register file: 32×32 with two asynchronous read ports and one write port on the clock edge. `x0` always reads 0 and writes to it are discarded.
- Shifts use `shamt[4:0]`. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Branch and JAL targets are PC+imm. The JALR target is (rs1+imm) & ~1. The link register receives PC+4.
- Memory address is rs1+imm. Misaligned accesses are not trapped.
  - Word accesses ignore `addr[1:0]`.
  - Halfword accesses use `addr[1]` and ignore `addr[0]`.
- Stores:
  - `be` is 4'b1111 for SW, 4'b0011 or 4'b1100 for SH, and one-hot by `addr[1:0]` for SB.
  - `wdata` replicates rs2 across lanes: `{4{rs2[7:0]}}` for SB, `{2{rs2[15:0]}}` for SH.
- Loads extract the selected lane from `rdata`. LB/LH sign-extend; LBU/LHU zero-extend.
- `we` is high only in a cycle executing a store that is not pre-empted by an interrupt. Otherwise `we`=0 and `be`=0.
- CSRs:
  - `mstatus`: only MIE (bit 3) and MPIE (bit 7) are implemented; all other bits read 0.
  - `mtvec`: full 32 bits; the trap target is `mtvec` & ~3.
  - `mepc`: bits [1:0] are always 0.
  - `mcause`: full 32 bits.
  - Unimplemented CSR addresses read 0 and ignore writes.
  - CSRRS/CSRRC with rs1=x0 do not write the CSR.
- Interrupt entry happens when `ext_int`=1 and MIE=1 at a rising edge. The instruction at PC is squashed (no register, memory or CSR write), and:
  - `mepc`←PC, `mcause`←32'h8000_000B;
  - MPIE←MIE, MIE←0;
  - PC←`mtvec`&~3.
- ECALL: `mepc`←PC, `mcause`←32'd11, MPIE←MIE, MIE←0, PC←`mtvec`&~3.
- MRET: PC←`mepc`, MIE←MPIE, MPIE←1.
- If an interrupt and an ECALL or MRET coincide, the interrupt wins and the ECALL or MRET is squashed.

## Timing
- Reset (`rst`=0), asynchronous:
  - PC=0;
  - all GPRs, `mtvec`, `mepc` and `mcause` =0;
  - MIE=MPIE=0;
  - `we`=0 and `be`=0 are forced combinationally while reset is asserted.
- Reset asserted mid-program aborts the current instruction; no write occurs on that edge.
- CPI = 1. Fetch, decode, execute, memory access and write-back are all combinational within the cycle. PC, GPR, CSR and data-memory writes commit on the same rising edge.
- A store followed by a load to the same address returns the new data one cycle later.
- `ext_int` is sampled only at rising edges. The first instruction executed after entry is at `mtvec`.

## Structure
- Shared package `scpu_pkg`: opcode constants, funct3 and funct7 constants, ALU-op enum, CSR address constants (0x300, 0x305, 0x341, 0x342), and the cause codes `CAUSE_MEXT`=32'h8000_000B and `CAUSE_ECALL`=11.
- The `data_memory_face` interface (with `cpu` and `mem` modports) is declared in the common header, not in the core.
- One sub-module, `scpu_alu`: a combinational 32-bit ALU taking two operands and an ALU-op enum, producing a result and a zero flag. Decode, register file, CSRs and load/store lane logic live in `scpu`.

## Test plan
- Reset and ALU: `addi x1,x0,5`; `addi x2,x0,-3`; `add x3,x1,x2`; `sltu x4,x1,x2` → x3=2, x4=1, `PC_out`=16 after 4 cycles. Asserting `rst` low mid-run → PC=0 and x3=0 immediately.
- Memory: `sw` of x5=0xA1B2C3D4 to address 0x10, then `lb`/`lbu`/`lh` at 0x13 and 0x12 →
  - `we` pulses one cycle with `be`=4'b1111;
  - `lb` at 0x13 → 0xFFFFFFA1, `lbu` → 0x000000A1, `lh` at 0x12 → 0xFFFFA1B2;
  - `sb` of 0x77 to 0x11 → `be`=4'b0010 and `wdata`=0x77777777.
- Control flow: `beq` taken and not taken, `jal x1,+8`, `jalr x0,0(x1)` → correct PC sequence, x1=PC+4, and a write to x0 stays 0.
- Interrupt: set `mtvec`=0x100, set MIE, raise `ext_int` during a `sw` → store suppressed (`we`=0), `mepc`=address of the store, `mcause`=0x8000000B, PC=0x100. A handler MRET → resumes at the store with MIE=1.
- Masked interrupt and ECALL: `ext_int`=1 with MIE=0 → ignored. ECALL at PC 0x20 → `mepc`=0x20, `mcause`=11, PC=`mtvec`.
- Illegal encoding 32'hFFFFFFFF → PC+4, with no register or memory write.
